// File: rtl/bomb_pkg.sv
// Shared types and helpers for the player bomb pool.
package bomb_pkg;

  typedef enum logic [1:0] {
    BS_FREE  = 2'd0,
    BS_FUSE  = 2'd1,
    BS_FLAME = 2'd2
  } bomb_state_t;

  // Off-screen parking coordinates for a free slot.
  localparam logic [9:0] DEF_HIDE_X = 10'd700;
  localparam logic [9:0] DEF_HIDE_Y = 10'd500;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } bomb_pos_t;

  // Snap a pixel coordinate down to its tile origin, then add the sprite offset.
  function automatic logic [9:0] snap_coord(input logic [9:0] c,
                                            input int unsigned tile_log2,
                                            input logic [9:0] ofs);
    logic [9:0] mask;
    mask = ~((10'd1 << tile_log2) - 10'd1);
    return (c & mask) + ofs;
  endfunction

endpackage

// File: rtl/bomb_slot.sv
// One bomb slot: FREE -> FUSE -> FLAME -> FREE with a frame counter and a
// position that is latched at allocation and held for the whole lifetime.
module bomb_slot import bomb_pkg::*; #(
  parameter int unsigned FUSE_FRAMES  = 120,
  parameter int unsigned FLAME_FRAMES = 30,
  parameter int unsigned CNT_W        = 7,
  parameter logic [9:0]  HIDE_X       = DEF_HIDE_X,
  parameter logic [9:0]  HIDE_Y       = DEF_HIDE_Y
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic        alloc,
  input  logic        detonate,
  input  logic [9:0]  tx,
  input  logic [9:0]  ty,
  output bomb_state_t state,
  output bomb_pos_t   pos,
  output logic        explode_pulse
);

  localparam logic [CNT_W-1:0] FUSE_LAST  = CNT_W'(FUSE_FRAMES - 1);
  localparam logic [CNT_W-1:0] FLAME_LAST = CNT_W'(FLAME_FRAMES - 1);

  bomb_state_t      state_r;
  logic [CNT_W-1:0] cnt_r;
  bomb_pos_t        pos_r;
  logic             pulse_r;

  // Slot FSM: counter, position and the one-cycle explosion pulse.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_r <= BS_FREE;
      cnt_r   <= '0;
      pos_r   <= '{x: HIDE_X, y: HIDE_Y};
      pulse_r <= 1'b0;
    end else begin
      pulse_r <= 1'b0;
      case (state_r)
        BS_FREE: begin
          if (alloc) begin
            state_r <= BS_FUSE;
            cnt_r   <= '0;
            pos_r   <= '{x: tx, y: ty};
          end else begin
            cnt_r   <= '0;
          end
        end
        BS_FUSE: begin
          if ((cnt_r == FUSE_LAST) || detonate) begin
            state_r <= BS_FLAME;
            cnt_r   <= '0;
            pulse_r <= 1'b1;
          end else begin
            cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        BS_FLAME: begin
          if (cnt_r == FLAME_LAST) begin
            state_r <= BS_FREE;
            cnt_r   <= '0;
            pos_r   <= '{x: HIDE_X, y: HIDE_Y};
          end else begin
            cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r <= BS_FREE;
          cnt_r   <= '0;
          pos_r   <= '{x: HIDE_X, y: HIDE_Y};
        end
      endcase
    end
  end

  assign state         = state_r;
  assign pos           = pos_r;
  assign explode_pulse = pulse_r;

endmodule

// File: rtl/bomb_pool.sv
// Pool of player bombs: edge-detects the place request, snaps the player
// position to the tile grid, rejects duplicates/full pool, and hands the
// request to the lowest free slot.
module bomb_pool import bomb_pkg::*; #(
  parameter int unsigned NUM_BOMBS    = 4,
  parameter int unsigned FUSE_FRAMES  = 120,
  parameter int unsigned FLAME_FRAMES = 30,
  parameter int unsigned TILE_LOG2    = 5,
  parameter logic [9:0]  BOMB_OFS     = 10'd4,
  parameter logic [9:0]  HIDE_X       = DEF_HIDE_X,
  parameter logic [9:0]  HIDE_Y       = DEF_HIDE_Y,
  parameter logic [9:0]  BOMB_XS      = 10'd20,
  parameter logic [9:0]  BOMB_YS      = 10'd25
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic                    make,
  input  logic                    detonate,
  input  logic [9:0]              userX,
  input  logic [9:0]              userY,
  output logic [NUM_BOMBS-1:0]    bomb_active,
  output logic [NUM_BOMBS-1:0]    bomb_flame,
  output logic [NUM_BOMBS-1:0]    explode_pulse,
  output logic [10*NUM_BOMBS-1:0] bombX,
  output logic [10*NUM_BOMBS-1:0] bombY,
  output logic [9:0]              bombXS,
  output logic [9:0]              bombYS,
  output logic                    pool_full
);

  localparam int unsigned MAX_FRAMES = (FUSE_FRAMES > FLAME_FRAMES) ? FUSE_FRAMES : FLAME_FRAMES;
  localparam int unsigned CNT_W      = $clog2(MAX_FRAMES + 1);

  logic                 make_q_r;
  logic                 req_s;
  logic [9:0]           tx_s;
  logic [9:0]           ty_s;
  logic                 dup_s;
  logic                 found_s;
  logic [NUM_BOMBS-1:0] grant_s;
  logic [NUM_BOMBS-1:0] alloc_s;
  logic [NUM_BOMBS-1:0] active_s;
  logic [NUM_BOMBS-1:0] flame_s;
  bomb_state_t          slot_state_s [NUM_BOMBS];
  bomb_pos_t            slot_pos_s   [NUM_BOMBS];

  // Previous make level, so only a rising edge counts as a request.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      make_q_r <= 1'b0;
    end else begin
      make_q_r <= make;
    end
  end

  assign req_s = make & ~make_q_r;
  assign tx_s  = snap_coord(userX, TILE_LOG2, BOMB_OFS);
  assign ty_s  = snap_coord(userY, TILE_LOG2, BOMB_OFS);

  // A live bomb already sitting on the target tile blocks the request.
  always_comb begin
    dup_s = 1'b0;
    for (int i = 0; i < NUM_BOMBS; i++) begin
      if (active_s[i] && (slot_pos_s[i].x == tx_s) && (slot_pos_s[i].y == ty_s)) begin
        dup_s = 1'b1;
      end else begin
        dup_s = dup_s;
      end
    end
  end

  // Lowest-index free slot wins; grant is dropped unless the request is accepted.
  always_comb begin
    grant_s = '0;
    found_s = 1'b0;
    for (int i = 0; i < NUM_BOMBS; i++) begin
      if (!active_s[i] && !found_s) begin
        grant_s[i] = 1'b1;
        found_s    = 1'b1;
      end else begin
        grant_s[i] = 1'b0;
      end
    end
    if (req_s && !pool_full && !dup_s) begin
      alloc_s = grant_s;
    end else begin
      alloc_s = '0;
    end
  end

  for (genvar g = 0; g < NUM_BOMBS; g++) begin : g_slot
    bomb_slot #(
      .FUSE_FRAMES  (FUSE_FRAMES),
      .FLAME_FRAMES (FLAME_FRAMES),
      .CNT_W        (CNT_W),
      .HIDE_X       (HIDE_X),
      .HIDE_Y       (HIDE_Y)
    ) u_slot (
      .frame_clk     (frame_clk),
      .Reset         (Reset),
      .alloc         (alloc_s[g]),
      .detonate      (detonate),
      .tx            (tx_s),
      .ty            (ty_s),
      .state         (slot_state_s[g]),
      .pos           (slot_pos_s[g]),
      .explode_pulse (explode_pulse[g])
    );

    assign active_s[g]        = (slot_state_s[g] != BS_FREE);
    assign flame_s[g]         = (slot_state_s[g] == BS_FLAME);
    assign bombX[10*g +: 10]  = slot_pos_s[g].x;
    assign bombY[10*g +: 10]  = slot_pos_s[g].y;
  end

  assign bomb_active = active_s;
  assign bomb_flame  = flame_s;
  assign pool_full   = &active_s;
  assign bombXS      = BOMB_XS;
  assign bombYS      = BOMB_YS;

endmodule
